// File: rtl/countdown_pkg.sv
// Shared types and helpers for the hh:mm:ss countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  // Saturate a field value to its legal maximum.
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/down_cnt_mod.sv
// One down-counting time field; wraps to MAX and raises borrow when decremented at zero.
module down_cnt_mod #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         borrow
);

  assign borrow = en && (value == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        value <= '0;
    else if (load)    value <= load_val;
    else if (en)      value <= (value == '0) ? W'(MAX) : value - 1'b1;
  end

endmodule

// File: rtl/countdown_timer.sv
// hh:mm:ss countdown timer with load/start/pause control and a one-cycle done pulse.
// Optional AUTO_RELOAD_EN: on expiry reload the preset and keep running.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int W      = 6,
  parameter int HH_MAX = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic         start,
  input  logic         pause,
  input  logic [W-1:0] ss_in,
  input  logic [W-1:0] mm_in,
  input  logic [W-1:0] hh_in,
  output logic [W-1:0] ss,
  output logic [W-1:0] mm,
  output logic [W-1:0] hh,
  output logic         running,
  output logic         done
);

  state_t state, state_nxt;
  logic done_nxt, ld, dec;
  logic [W-1:0] ld_ss, ld_mm, ld_hh;
  logic [W-1:0] in_ss, in_mm, in_hh;
  logic ss_borrow, mm_borrow, hh_borrow;
  logic fld_ld;
  logic [W-1:0] fld_ss, fld_mm, fld_hh;
  logic is_zero, is_one;

  assign in_ss = W'(clamp(32'(ss_in), SEC_MAX));
  assign in_mm = W'(clamp(32'(mm_in), MIN_MAX));
  assign in_hh = W'(clamp(32'(hh_in), 32'(HH_MAX)));

  assign is_zero = (ss == '0) && (mm == '0) && (hh == '0);
  assign is_one  = (ss == W'(1)) && (mm == '0) && (hh == '0);

`ifdef AUTO_RELOAD_EN
  logic [W-1:0] pre_ss, pre_mm, pre_hh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_ss <= '0;
      pre_mm <= '0;
      pre_hh <= '0;
    end else if (load) begin
      pre_ss <= in_ss;
      pre_mm <= in_mm;
      pre_hh <= in_hh;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ld        = 1'b0;
    dec       = 1'b0;
    ld_ss     = in_ss;
    ld_mm     = in_mm;
    ld_hh     = in_hh;
    if (load) begin
      ld        = 1'b1;
      state_nxt = IDLE;
    end else if (start && (state == IDLE || state == PAUSE)) begin
      if (is_zero) begin
        state_nxt = EXPIRED;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else if (pause && state == RUN) begin
      state_nxt = PAUSE;
    end else if (state == RUN && tick) begin
      if (is_one) begin
        done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
        if ({pre_ss, pre_mm, pre_hh} == '0) begin
          dec       = 1'b1;
          state_nxt = EXPIRED;
        end else begin
          ld    = 1'b1;
          ld_ss = pre_ss;
          ld_mm = pre_mm;
          ld_hh = pre_hh;
        end
`else
        dec       = 1'b1;
        state_nxt = EXPIRED;
`endif
      end else begin
        dec = 1'b1;
      end
    end
  end

  // An hour borrow means the count would drop below zero: floor it instead of wrapping.
  assign fld_ld = ld | hh_borrow;
  assign fld_ss = hh_borrow ? '0 : ld_ss;
  assign fld_mm = hh_borrow ? '0 : ld_mm;
  assign fld_hh = hh_borrow ? '0 : ld_hh;

  down_cnt_mod #(.W(W), .MAX(SEC_MAX)) u_ss (
    .clk(clk), .reset(reset), .en(dec), .load(fld_ld), .load_val(fld_ss),
    .value(ss), .borrow(ss_borrow)
  );

  down_cnt_mod #(.W(W), .MAX(MIN_MAX)) u_mm (
    .clk(clk), .reset(reset), .en(ss_borrow), .load(fld_ld), .load_val(fld_mm),
    .value(mm), .borrow(mm_borrow)
  );

  down_cnt_mod #(.W(W), .MAX(HH_MAX)) u_hh (
    .clk(clk), .reset(reset), .en(mm_borrow), .load(fld_ld), .load_val(fld_hh),
    .value(hh), .borrow(hh_borrow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  localparam int W = 6;

  logic clk, reset, tick, load, start, pause;
  logic [W-1:0] ss_in, mm_in, hh_in, ss, mm, hh;
  logic running, done;
  int checks = 0;
  int failures = 0;

  countdown_timer #(.W(W), .HH_MAX(23)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start), .pause(pause),
    .ss_in(ss_in), .mm_in(mm_in), .hh_in(hh_in),
    .ss(ss), .mm(mm), .hh(hh), .running(running), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Compare the whole count as hh*10000 + mm*100 + ss for readable reports.
  task automatic chk_t(input string tag, input int h, input int m, input int s);
    chk(tag, 32'(hh) * 10000 + 32'(mm) * 100 + 32'(ss), 32'(h * 10000 + m * 100 + s));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick = 0; load = 0; start = 0; pause = 0;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    hh_in = W'(h); mm_in = W'(m); ss_in = W'(s);
    load = 1;
    step();
  endtask

  task automatic do_tick();
    tick = 1;
    step();
  endtask

  initial begin
    reset = 1; tick = 0; load = 0; start = 0; pause = 0;
    ss_in = '0; mm_in = '0; hh_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_t("rst_count", 0, 0, 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    reset = 0;
    step();

    // start with a zero count expires immediately
    start = 1; step();
    chk("zero_start_done", 32'(done), 1);
    chk("zero_start_run", 32'(running), 0);
    step();
    chk("zero_start_done_clr", 32'(done), 0);

    // 1: single borrow
    do_load(0, 1, 0);
    start = 1; step();
    chk("t1_running", 32'(running), 1);
    do_tick(); chk_t("t1_tick1", 0, 0, 59);
    do_tick(); chk_t("t1_tick2", 0, 0, 58);
    chk("t1_running2", 32'(running), 1);

    // 2: double borrow
    do_load(1, 0, 0);
    start = 1; step();
    do_tick(); chk_t("t2_dbl_borrow", 0, 59, 59);

    // 3: expiry
    do_load(0, 0, 2);
    start = 1; step();
    do_tick(); chk_t("t3_tick1", 0, 0, 1);
    chk("t3_done_early", 32'(done), 0);
    do_tick(); chk_t("t3_zero", 0, 0, 0);
    chk("t3_done", 32'(done), 1);
    chk("t3_not_running", 32'(running), 0);
    step(); chk("t3_done_clr", 32'(done), 0);
    do_tick(); do_tick(); chk_t("t3_hold", 0, 0, 0);
    chk("t3_done_stays", 32'(done), 0);
    start = 1; step();
    chk("t3_start_expired", 32'(running), 0);
    chk("t3_start_no_done", 32'(done), 0);

    // 4: pause and resume
    do_load(0, 0, 10);
    start = 1; step();
    do_tick(); chk_t("t4_run", 0, 0, 9);
    pause = 1; step();
    chk("t4_paused", 32'(running), 0);
    do_tick(); do_tick(); do_tick();
    chk_t("t4_hold", 0, 0, 9);
    start = 1; step();
    chk("t4_resumed", 32'(running), 1);
    chk_t("t4_resume_nochg", 0, 0, 9);
    do_tick(); chk_t("t4_dec", 0, 0, 8);

    // 5: load+start+pause together, then async reset mid-run
    hh_in = 0; mm_in = 5; ss_in = 0;
    load = 1; start = 1; pause = 1; step();
    chk_t("t5_loaded", 0, 5, 0);
    chk("t5_idle", 32'(running), 0);
    start = 1; step();
    do_tick(); chk_t("t5_run", 0, 4, 59);
    reset = 1; #2;
    chk_t("t5_async_rst", 0, 0, 0);
    chk("t5_rst_running", 32'(running), 0);
    chk("t5_rst_done", 32'(done), 0);
    @(negedge clk); reset = 0;
    step();

    // load during run aborts without done
    do_load(0, 0, 1);
    start = 1; step();
    hh_in = 0; mm_in = 0; ss_in = 5;
    load = 1; tick = 1; step();
    chk_t("abort_loaded", 0, 0, 5);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_idle", 32'(running), 0);

    // 6: clamping
    do_load(30, 10, 63);
    chk_t("t6_clamp", 23, 10, 59);
    do_load(0, 60, 0);
    chk_t("t6_clamp_mm", 0, 59, 0);

    // expiry with / without auto reload
    do_load(0, 0, 2);
    start = 1; step();
    do_tick(); do_tick();
    chk("ar_done", 32'(done), 1);
`ifdef AUTO_RELOAD_EN
    chk_t("ar_reload", 0, 0, 2);
    chk("ar_running", 32'(running), 1);
    step(); chk("ar_done_clr", 32'(done), 0);
    do_tick(); chk_t("ar_continue", 0, 0, 1);
`else
    chk_t("ar_hold_zero", 0, 0, 0);
    chk("ar_stopped", 32'(running), 0);
    step(); chk("ar_done_clr", 32'(done), 0);
    do_tick(); chk_t("ar_still_zero", 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
